// File: rtl/audio_clk_pkg.sv
// Shared frame-timing definitions for the codec clock generator.
// A frame is 256 cycles of the 256fs clock. The bit clock is derived by dividing
// the frame index, so every tap is a pure function of the index.
package audio_clk_pkg;

  localparam int unsigned FRAME_LEN   = 256;
  localparam int unsigned SLOT_BITS   = 32;
  localparam int unsigned FRAME_IDX_W = $clog2(FRAME_LEN);

  // Number of low frame-index bits consumed by one BICK period (L = log2(BICK_DIV)).
  function automatic int unsigned bick_shift(input int unsigned bick_div);
    return (bick_div == 4) ? 2 : 1;
  endfunction

  // All frame-derived outputs, registered together in the top module.
  typedef struct packed {
    logic       bick;
    logic       lrck;
    logic       sample_strobe;
    logic       bit_launch;
    logic       bit_capture;
    logic [6:0] bit_idx;
  } frame_taps_t;

  // Decode a frame index into the serialiser taps for a given bit-clock shift.
  function automatic frame_taps_t frame_decode(input logic [FRAME_IDX_W-1:0] k,
                                               input int unsigned shift);
    logic [FRAME_IDX_W-1:0] mask;
    logic [FRAME_IDX_W-1:0] half;
    frame_taps_t t;
    mask            = FRAME_IDX_W'((1 << shift) - 1);
    half            = FRAME_IDX_W'(1 << (shift - 1));
    t.bick          = |(k & half);
    t.lrck          = k[FRAME_IDX_W-1];
    t.sample_strobe = (k == '0);
    t.bit_launch    = ((k & mask) == '0);
    t.bit_capture   = ((k & mask) == half);
    t.bit_idx       = 7'(k >> shift);
    return t;
  endfunction

endpackage

// File: rtl/codec_pwr_seq.sv
// Codec power sequencer: releases pdn_n a fixed number of clocks after reset,
// then counts frame starts with the codec running and raises ready once the
// warm-up interval has elapsed. A resync restarts the warm-up.
module codec_pwr_seq #(
  parameter int unsigned PDN_CYCLES    = 4096,
  parameter int unsigned WARMUP_FRAMES = 16
) (
  input  logic clk_256fs,
  input  logic rst_n,
  input  logic sample_strobe,  // strobe value being registered on this edge
  input  logic resync,
  output logic pdn_n,
  output logic ready
);

  localparam int unsigned PDN_W = $clog2(PDN_CYCLES + 1);
  localparam int unsigned WU_W  = $clog2(WARMUP_FRAMES + 1);
  localparam logic [PDN_W-1:0] PDN_TERM = PDN_W'(PDN_CYCLES);
  localparam logic [WU_W-1:0]  WU_TERM  = WU_W'(WARMUP_FRAMES);

  logic [PDN_W-1:0] pdn_cnt_q, pdn_cnt_next;
  logic [WU_W-1:0]  wu_cnt_q, wu_cnt_next;
  logic             pdn_n_q, pdn_n_next;
  logic             ready_q, ready_next;

  // Next-state for both counters; both saturate at their terminal value.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    pdn_cnt_next = pdn_cnt_q;
    wu_cnt_next  = wu_cnt_q;
    ready_next   = ready_q;

    if (pdn_cnt_q != PDN_TERM) pdn_cnt_next = pdn_cnt_q + 1'b1;
    pdn_n_next = (pdn_cnt_next == PDN_TERM);

    // The restart strobe that comes with a resync starts warm-up from zero; it is not counted.
    if (resync) begin
      wu_cnt_next = '0;
      ready_next  = 1'b0;
    end else begin
      if (sample_strobe && pdn_n_next && (wu_cnt_q != WU_TERM)) wu_cnt_next = wu_cnt_q + 1'b1;
      ready_next = ready_q | (wu_cnt_next == WU_TERM);
    end
  end

  // Sequencer state; reset drops pdn_n so the codec powers down again.
  always_ff @(posedge clk_256fs) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      pdn_cnt_q <= '0;
      wu_cnt_q  <= '0;
      pdn_n_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      pdn_cnt_q <= pdn_cnt_next;
      wu_cnt_q  <= wu_cnt_next;
      pdn_n_q   <= pdn_n_next;
      ready_q   <= ready_next;
    end
  end

  assign pdn_n = pdn_n_q;
  assign ready = ready_q;

endmodule

// File: rtl/codec_clkgen.sv
// Codec frame-timing generator running on the 256fs PLL clock.
// An 8-bit frame index drives BICK, LRCK, bit index and serialiser strobes;
// all taps are decoded from the index being loaded and registered, so every
// output is a flop and the first edge after reset already shows index 0.
module codec_clkgen
  import audio_clk_pkg::*;
#(
  parameter int unsigned BICK_DIV      = 2,
  parameter int unsigned PDN_CYCLES    = 4096,
  parameter int unsigned WARMUP_FRAMES = 16
) (
  input  logic       clk_256fs,
  input  logic       rst_n,
  input  logic       resync,
  output logic       bick,
  output logic       lrck,
  output logic       sample_strobe,
  output logic       bit_launch,
  output logic       bit_capture,
  output logic [6:0] bit_idx,
  output logic       pdn_n,
  output logic       ready
);

  localparam int unsigned L = bick_shift(BICK_DIV);

  if (!(BICK_DIV == 2 || BICK_DIV == 4)) begin : g_bad_bick_div
    $error("codec_clkgen: BICK_DIV must be 2 or 4, got %0d", BICK_DIV);
  end
  if (PDN_CYCLES < 1 || WARMUP_FRAMES < 1) begin : g_bad_counts
    $error("codec_clkgen: PDN_CYCLES and WARMUP_FRAMES must be >= 1");
  end

  logic [FRAME_IDX_W-1:0] k_q, k_next;
  logic                   running_q;
  frame_taps_t            taps_q, taps_next;

  // Next frame index: the first edge out of reset and any resync land on index 0.
  always_comb begin
    k_next    = (!running_q || resync) ? '0 : k_q + 1'b1;
    taps_next = frame_decode(k_next, L);
  end

  // Frame index and registered taps; reset clears outputs and parks the index at 0.
  always_ff @(posedge clk_256fs) begin
    if (!rst_n) begin
      k_q       <= '0;
      running_q <= 1'b0;
      taps_q    <= '0;
    end else begin
      k_q       <= k_next;
      running_q <= 1'b1;
      taps_q    <= taps_next;
    end
  end

  codec_pwr_seq #(
    .PDN_CYCLES   (PDN_CYCLES),
    .WARMUP_FRAMES(WARMUP_FRAMES)
  ) u_pwr_seq (
    .clk_256fs    (clk_256fs),
    .rst_n        (rst_n),
    .sample_strobe(taps_next.sample_strobe),
    .resync       (resync),
    .pdn_n        (pdn_n),
    .ready        (ready)
  );

  assign bick          = taps_q.bick;
  assign lrck          = taps_q.lrck;
  assign sample_strobe = taps_q.sample_strobe;
  assign bit_launch    = taps_q.bit_launch;
  assign bit_capture   = taps_q.bit_capture;
  assign bit_idx       = taps_q.bit_idx;

endmodule

// File: tb/tb_codec_clkgen.sv
// Self-checking bench: two instances (BICK_DIV=2 and 4, PDN_CYCLES=8,
// WARMUP_FRAMES=2) share clock, reset and resync and are compared each edge
// against an arithmetic frame/power model, plus directed edge checks.
module tb_codec_clkgen;

  localparam int PDN = 8;
  localparam int WU  = 2;

  logic clk_256fs = 1'b0;
  logic rst_n     = 1'b0;
  logic resync    = 1'b0;

  logic       bick_a, lrck_a, strobe_a, launch_a, capture_a, pdn_a, ready_a;
  logic [6:0] idx_a;
  logic       bick_b, lrck_b, strobe_b, launch_b, capture_b, pdn_b, ready_b;
  logic [6:0] idx_b;

  int n_compared   = 0;
  int n_mismatched = 0;

  // Model state: frame index, edges since reset exit, counted warm-up frames.
  int m_k      = 0;
  int m_edges  = 0;
  int m_frames = 0;
  bit m_run    = 0;
  bit m_clean  = 0;  // no resync since the last reset

  always #5 clk_256fs = ~clk_256fs;

  codec_clkgen #(.BICK_DIV(2), .PDN_CYCLES(PDN), .WARMUP_FRAMES(WU)) dut_a (
    .clk_256fs(clk_256fs), .rst_n(rst_n), .resync(resync),
    .bick(bick_a), .lrck(lrck_a), .sample_strobe(strobe_a), .bit_launch(launch_a),
    .bit_capture(capture_a), .bit_idx(idx_a), .pdn_n(pdn_a), .ready(ready_a));

  codec_clkgen #(.BICK_DIV(4), .PDN_CYCLES(PDN), .WARMUP_FRAMES(WU)) dut_b (
    .clk_256fs(clk_256fs), .rst_n(rst_n), .resync(resync),
    .bick(bick_b), .lrck(lrck_b), .sample_strobe(strobe_b), .bit_launch(launch_b),
    .bit_capture(capture_b), .bit_idx(idx_b), .pdn_n(pdn_b), .ready(ready_b));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_compared++;
    if (obs !== exp_v) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h (t=%0t edge=%0d)", tag, obs, exp_v, $time, m_edges);
    end
  endtask

  // Advance the model by one clock edge using the inputs applied to that edge.
  task automatic model_edge();
    if (!rst_n) begin
      m_k = 0; m_edges = 0; m_frames = 0; m_run = 0; m_clean = 1;
    end else begin
      m_edges++;
      m_k   = (!m_run || resync) ? 0 : (m_k + 1) % 256;
      m_run = 1;
      if (resync) begin
        m_frames = 0;
        m_clean  = 0;
      end else if (m_k == 0 && m_edges >= PDN) begin
        m_frames++;
      end
    end
  endtask

  // Expected {pdn_n, ready, strobe, launch, capture, bick, lrck, bit_idx}.
  function automatic logic [13:0] expect_vec(input int div);
    logic [13:0] v;
    if (!m_run) return '0;
    v[13]  = (m_edges >= PDN);
    v[12]  = (m_frames >= WU);
    v[11]  = (m_k == 0);
    v[10]  = (m_k % div == 0);
    v[9]   = (m_k % div == div / 2);
    v[8]   = ((m_k / (div / 2)) % 2 == 1);
    v[7]   = (m_k >= 128);
    v[6:0] = 7'(m_k / div);
    return v;
  endfunction

  task automatic step(input logic r, input logic s);
    rst_n  = r;
    resync = s;
    @(posedge clk_256fs);
    model_edge();
    #1;
    check("dut_div2", 32'({pdn_a, ready_a, strobe_a, launch_a, capture_a, bick_a, lrck_a, idx_a}),
          32'(expect_vec(2)));
    check("dut_div4", 32'({pdn_b, ready_b, strobe_b, launch_b, capture_b, bick_b, lrck_b, idx_b}),
          32'(expect_vec(4)));
    if (m_clean && rst_n) begin
      case (m_edges)
        1: begin
          check("e1_strobe", 32'(strobe_a), 1); check("e1_launch", 32'(launch_a), 1);
          check("e1_bick", 32'(bick_a), 0);     check("e1_lrck", 32'(lrck_a), 0);
          check("e1_idx", 32'(idx_a), 0);
        end
        2:   begin check("e2_bick", 32'(bick_a), 1); check("e2_capture", 32'(capture_a), 1); end
        3:   begin check("e3_bick4", 32'(bick_b), 1); check("e3_capture4", 32'(capture_b), 1); end
        7:   check("e7_pdn", 32'(pdn_a), 0);
        8:   check("e8_pdn", 32'(pdn_a), 1);
        128: check("e128_lrck", 32'(lrck_a), 0);
        129: check("e129_lrck", 32'(lrck_a), 1);
        255: check("e255_idx", 32'(idx_a), 127);
        256: begin check("e256_idx4", 32'(idx_b), 63); check("e256_strobe", 32'(strobe_a), 0); end
        257: check("e257_strobe", 32'(strobe_a), 1);
        512: check("e512_ready", 32'(ready_a), 0);
        513: begin check("e513_ready", 32'(ready_a), 1); check("e513_strobe", 32'(strobe_a), 1); end
        default: ;
      endcase
    end
  endtask

  initial begin
    // Reset held for two edges: all outputs zero.
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("rst_zero_a", 32'({pdn_a, ready_a, strobe_a, launch_a, capture_a, bick_a, lrck_a, idx_a}), 0);

    // Clean start through pdn release and warm-up.
    for (int i = 0; i < 612; i++) step(1'b1, 1'b0);

    // Resync at k=100 with ready high.
    for (int i = 0; i < 300 && m_k != 100; i++) step(1'b1, 1'b0);
    check("seek_k100", 32'(m_k), 100);
    check("pre_resync_ready", 32'(ready_a), 1);
    step(1'b1, 1'b1);
    check("resync_strobe", 32'(strobe_a), 1);
    check("resync_ready", 32'(ready_a), 0);
    check("resync_pdn", 32'(pdn_a), 1);
    for (int i = 0; i < 511; i++) step(1'b1, 1'b0);
    check("rewarm_not_yet", 32'(ready_a), 0);
    step(1'b1, 1'b0);
    check("rewarm_ready", 32'(ready_a), 1);

    // Single-edge reset mid-frame at k=77.
    for (int i = 0; i < 300 && m_k != 77; i++) step(1'b1, 1'b0);
    check("seek_k77", 32'(m_k), 77);
    step(1'b0, 1'b0);
    check("midrst_zero_b", 32'({pdn_b, ready_b, strobe_b, launch_b, capture_b, bick_b, lrck_b, idx_b}), 0);
    for (int i = 0; i < 600; i++) step(1'b1, 1'b0);

    // Randomised stretch with occasional resync and reset.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 2499) != 0), ($urandom_range(0, 999) == 0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
